if_stage_fetch: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register of the ARM pipeline.
//  - Holds the PC and fetches from a variable-latency instruction memory, at most one request outstanding.
//  - Presents {instr, pc+4, valid} to the ID stage.
//  - Consumes the hazard unit's freeze (stall) and the EXE stage's branch redirect (flush).

---
 rtl/if_stage_fetch.sv | 117 +++++++++++
 tb/tb_if_stage_fetch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Allows one outstanding request to a variable-latency instruction memory.
module if_stage_fetch #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] instr_out,
  output logic              valid_out
);

  typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                discard_q, discard_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                load;
  logic [DATA_W-1:0]   load_data;
  logic [ADDR_W-1:0]   pc_plus4;
  logic                accept;

  assign imem_req  = rst && (state_q == StFetch);
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;
  assign pc_plus4  = pc_q + ADDR_W'(4);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    hold_d    = hold_q;
    load      = 1'b0;
    load_data = hold_q;
    unique case (state_q)
      StFetch: begin
        if (accept) begin
          state_d   = StWait;
          // A redirect in the accept cycle makes the in-flight response stale.
          discard_d = branch_taken;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          if (discard_q || branch_taken) begin
            discard_d = 1'b0;
            state_d   = StFetch;
          end else if (!freeze) begin
            load      = 1'b1;
            load_data = imem_rdata;
            state_d   = StFetch;
          end else begin
            hold_d  = imem_rdata;
            state_d = StHold;
          end
        end else if (branch_taken) begin
          discard_d = 1'b1;
        end
      end
      StHold: begin
        if (branch_taken) begin
          state_d = StFetch;
        end else if (!freeze) begin
          load      = 1'b1;
          load_data = hold_q;
          state_d   = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
    if (load) pc_d = pc_plus4;
    if (branch_taken) pc_d = branch_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      hold_q    <= hold_d;
    end
  end

  // IF/ID register: a flush beats a load, and a load beats a freeze hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out    <= '0;
      instr_out <= '0;
      valid_out <= 1'b0;
    end else if (branch_taken) begin
      valid_out <= 1'b0;
    end else if (load) begin
      pc_out    <= pc_plus4;
      instr_out <= load_data;
      valid_out <= 1'b1;
    end else if (!freeze) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch with a simple latency-programmable memory model.
module tb_if_stage_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;

  int checks   = 0;
  int failures = 0;

  // Memory model: word at an address equals the address unless overridden.
  logic        pend;
  logic [31:0] paddr;
  int          cnt;
  int          lat = 1;
  logic        use_override = 1'b0;
  logic [31:0] override_data = 32'h0;

  always #5 clk = ~clk;

  if_stage_fetch #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_out      (pc_out),
    .instr_out   (instr_out),
    .valid_out   (valid_out)
  );

  assign imem_rvalid = pend && (cnt == 0);
  assign imem_rdata  = use_override ? override_data : paddr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend  <= 1'b0;
      paddr <= 32'h0;
      cnt   <= 0;
    end else begin
      if (imem_rvalid) pend <= 1'b0;
      if (imem_req && imem_ready) begin
        pend  <= 1'b1;
        paddr <= imem_addr;
        cnt   <= lat - 1;
      end else if (pend && cnt > 0) begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] ins);
    check({tag, ".valid"}, {31'h0, valid_out}, {31'h0, v});
    check({tag, ".pc"}, pc_out, pc);
    check({tag, ".instr"}, instr_out, ins);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0; imem_ready = 1'b1;
    step();
    step();
    check_ifid("reset", 1'b0, 32'h0, 32'h0);
    check("reset.req", {31'h0, imem_req}, 32'h0);
    rst = 1'b1;
    #1;
    check("fetch0.req", {31'h0, imem_req}, 32'h1);
    check("fetch0.addr", imem_addr, 32'h0);

    // 1: one instruction every second cycle.
    step();
    check("t1.e1.valid", {31'h0, valid_out}, 32'h0);
    check("t1.e1.req", {31'h0, imem_req}, 32'h0);
    step(); check_ifid("t1.e2", 1'b1, 32'd4, 32'd0);
    check("t1.e2.addr", imem_addr, 32'd4);
    step(); check("t1.e3.valid", {31'h0, valid_out}, 32'h0);
    step(); check_ifid("t1.e4", 1'b1, 32'd8, 32'd4);
    step(); check("t1.e5.valid", {31'h0, valid_out}, 32'h0);
    step(); check_ifid("t1.e6", 1'b1, 32'd12, 32'd8);

    // 2: freeze across the response; IF/ID must hold the previous entry.
    use_override = 1'b1; override_data = 32'hE3A01005;
    freeze = 1'b1;
    step(); check_ifid("t2.e7", 1'b1, 32'd12, 32'd8);
    step(); check_ifid("t2.e8", 1'b1, 32'd12, 32'd8);
    check("t2.e8.req", {31'h0, imem_req}, 32'h0);
    step(); check_ifid("t2.e9", 1'b1, 32'd12, 32'd8);
    freeze = 1'b0;
    step(); check_ifid("t2.e10", 1'b1, 32'd16, 32'hE3A01005);
    check("t2.e10.addr", imem_addr, 32'd16);
    use_override = 1'b0;

    // 3: redirect while waiting; the late response must be dropped.
    lat = 3;
    step(); check("t3.e11.valid", {31'h0, valid_out}, 32'h0);
    branch_taken = 1'b1; branch_addr = 32'h100;
    step(); check("t3.e12.valid", {31'h0, valid_out}, 32'h0);
    branch_taken = 1'b0;
    step(); check("t3.e13.rvalid", {31'h0, imem_rvalid}, 32'h1);
    step(); check_ifid("t3.e14", 1'b0, 32'd16, 32'hE3A01005);
    check("t3.e14.req", {31'h0, imem_req}, 32'h1);
    check("t3.e14.addr", imem_addr, 32'h100);
    lat = 1;
    step();
    step(); check_ifid("t3.e16", 1'b1, 32'h104, 32'h100);

    // 4: redirect together with freeze while holding a buffered instruction.
    freeze = 1'b1;
    step(); check_ifid("t4.e17", 1'b1, 32'h104, 32'h100);
    step(); check("t4.e18.req", {31'h0, imem_req}, 32'h0);
    branch_taken = 1'b1; branch_addr = 32'h200;
    step(); check("t4.e19.valid", {31'h0, valid_out}, 32'h0);
    check("t4.e19.req", {31'h0, imem_req}, 32'h1);
    check("t4.e19.addr", imem_addr, 32'h200);
    branch_taken = 1'b0; freeze = 1'b0;
    step();
    step(); check_ifid("t4.e21", 1'b1, 32'h204, 32'h200);

    // 5: memory not ready for five cycles.
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5.req", {31'h0, imem_req}, 32'h1);
      check("t5.addr", imem_addr, 32'h204);
      check_ifid("t5.ifid", 1'b0, 32'h204, 32'h200);
    end
    imem_ready = 1'b1;
    step();
    step(); check_ifid("t5.load", 1'b1, 32'h208, 32'h204);

    // 6: asynchronous reset while a request is outstanding.
    step(); check("t6.req_wait", {31'h0, imem_req}, 32'h0);
    rst = 1'b0;
    #1;
    check_ifid("t6.rst", 1'b0, 32'h0, 32'h0);
    check("t6.rst.req", {31'h0, imem_req}, 32'h0);
    step();
    rst = 1'b1;
    #1;
    check("t6.restart.req", {31'h0, imem_req}, 32'h1);
    check("t6.restart.addr", imem_addr, 32'h0);
    step();
    step(); check_ifid("t6.load", 1'b1, 32'd4, 32'd0);

    // 7: redirect in fetch without accept, then pc+4 wrap.
    imem_ready = 1'b0;
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    step();
    check("t7.valid", {31'h0, valid_out}, 32'h0);
    check("t7.addr", imem_addr, 32'hFFFF_FFFC);
    check("t7.req", {31'h0, imem_req}, 32'h1);
    branch_taken = 1'b0; imem_ready = 1'b1;
    step();
    step(); check_ifid("t7.wrap", 1'b1, 32'h0, 32'hFFFF_FFFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
